fp_issue: RTL and testbench



---
 rtl/fp_wire.sv | 65 ++++++
 rtl/fp_issue.sv | 153 +++++++++++++++
 tb/tb_fp_issue.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_wire.sv
// rtl/fp_wire.sv - shared FP pipeline types, including issue-stage state and request record
package fp_wire;

    localparam int FP_TAG_MAX_W = 16;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmsub;
        logic fnmadd;
        logic fadd;
        logic fsub;
        logic fmul;
        logic fdiv;
        logic fsqrt;
        logic fsgnj;
        logic fcmp;
        logic fmax;
        logic fclass;
        logic fmv;
        logic fcvt;
    } fp_operation_type;

    localparam fp_operation_type init_fp_operation = '0;

    typedef struct packed {
        logic             enable;
        logic [31:0]      data1;
        logic [31:0]      data2;
        logic [31:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
    } fp_exe_in_type;

    localparam fp_exe_in_type init_fp_exe_in = '0;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    typedef logic [2:0] fp_issue_state_type;

    localparam fp_issue_state_type ST_IDLE  = 3'd0;
    localparam fp_issue_state_type ST_ISSUE = 3'd1;
    localparam fp_issue_state_type ST_WAIT  = 3'd2;
    localparam fp_issue_state_type ST_RESP  = 3'd3;
    localparam fp_issue_state_type ST_DRAIN = 3'd4;

    // Tag is carried at the widest supported width; the issue stage uses the low TAG_W bits.
    typedef struct packed {
        logic [31:0]             data1;
        logic [31:0]             data2;
        logic [31:0]             data3;
        fp_operation_type        op;
        logic [1:0]              fmt;
        logic [2:0]              rm;
        logic [FP_TAG_MAX_W-1:0] tag;
    } fp_issue_req_type;

    localparam fp_issue_req_type init_fp_issue_req = '0;

endpackage

// File: rtl/fp_issue.sv
// rtl/fp_issue.sv - FP issue stage: request accept, exe enable pulse, response return, sticky flags
import fp_wire::*;

module fp_issue #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data1,
    input  logic [31:0]      req_data2,
    input  logic [31:0]      req_data3,
    input  fp_operation_type req_op,
    input  logic [1:0]       req_fmt,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output fp_exe_in_type    fp_exe_i,
    input  fp_exe_out_type   fp_exe_o,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_error,
    output logic [4:0]       fflags,
    input  logic             fflags_clear,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fp_issue_state_type state;
    fp_issue_req_type   req_r;
    fp_issue_req_type   req_d;
    logic [CNT_W-1:0]   count;
    logic               count_done;
    logic               deliver;
    logic               tag_unused;

    assign req_ready  = (state == ST_IDLE) && !flush;
    assign busy       = (state != ST_IDLE);
    assign count_done = (count == CNT_LAST);
    assign deliver    = rsp_valid && rsp_ready && !flush;
    assign tag_unused = ^req_r.tag;

    always_comb begin
        req_d                 = init_fp_issue_req;
        req_d.data1           = req_data1;
        req_d.data2           = req_data2;
        req_d.data3           = req_data3;
        req_d.op              = req_op;
        req_d.fmt             = req_fmt;
        req_d.rm              = req_rm;
        req_d.tag[TAG_W-1:0]  = req_tag;
    end

    always_comb begin
        fp_exe_i = init_fp_exe_in;
        if (state == ST_ISSUE) begin
            fp_exe_i.enable = 1'b1;
            fp_exe_i.data1  = req_r.data1;
            fp_exe_i.data2  = req_r.data2;
            fp_exe_i.data3  = req_r.data3;
            fp_exe_i.op     = req_r.op;
            fp_exe_i.fmt    = req_r.fmt;
            fp_exe_i.rm     = req_r.rm;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_r      <= init_fp_issue_req;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
            rsp_error  <= 1'b0;
            fflags     <= '0;
        end else begin
            fflags <= (fflags_clear ? 5'b0 : fflags) | (deliver ? rsp_flags : 5'b0);
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_r <= req_d;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    count <= '0;
                    if (flush) begin
                        state <= fp_exe_o.ready ? ST_IDLE : ST_DRAIN;
                    end else if (fp_exe_o.ready) begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= fp_exe_o.result;
                        rsp_flags  <= fp_exe_o.flags;
                        rsp_tag    <= req_r.tag[TAG_W-1:0];
                        rsp_error  <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!count_done) begin
                        count <= count + 1'b1;
                    end
                    // A ready arriving on the terminal count still wins over the timeout.
                    if (flush) begin
                        state <= (fp_exe_o.ready || count_done) ? ST_IDLE : ST_DRAIN;
                    end else if (fp_exe_o.ready) begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= fp_exe_o.result;
                        rsp_flags  <= fp_exe_o.flags;
                        rsp_tag    <= req_r.tag[TAG_W-1:0];
                        rsp_error  <= 1'b0;
                        state      <= ST_RESP;
                    end else if (count_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_flags  <= '0;
                        rsp_tag    <= req_r.tag[TAG_W-1:0];
                        rsp_error  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!count_done) begin
                        count <= count + 1'b1;
                    end
                    if (fp_exe_o.ready || count_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_issue.sv
// tb/tb_fp_issue.sv - randomized scoreboard bench for fp_issue
module tb_fp_issue;
    import fp_wire::*;

    localparam int TO = 8;
    localparam int TW = 5;

    localparam int K_NORMAL     = 0;
    localparam int K_TIMEOUT    = 1;
    localparam int K_FLUSH_WAIT = 2;
    localparam int K_FLUSH_RESP = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_data1 = '0, req_data2 = '0, req_data3 = '0;
    fp_operation_type req_op = '0;
    logic [1:0]       req_fmt = '0;
    logic [2:0]       req_rm = '0;
    logic [TW-1:0]    req_tag = '0;
    logic             flush = 1'b0;
    fp_exe_in_type    fp_exe_i;
    fp_exe_out_type   fp_exe_o = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic [TW-1:0]    rsp_tag;
    logic             rsp_error;
    logic [4:0]       fflags;
    logic             fflags_clear = 1'b0;
    logic             busy;

    fp_issue #(.TIMEOUT_CYCLES(TO), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .req_op(req_op), .req_fmt(req_fmt), .req_rm(req_rm), .req_tag(req_tag),
        .flush(flush), .fp_exe_i(fp_exe_i), .fp_exe_o(fp_exe_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_error(rsp_error),
        .fflags(fflags), .fflags_clear(fflags_clear), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   result;
        logic [4:0]    flags;
        logic [TW-1:0] tag;
        logic          err;
        int            first_cyc;
        bit            drop;
    } rsp_exp_t;

    rsp_exp_t      rq[$];
    fp_exe_in_type iq[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor with its own sticky-flag model.
    logic [4:0] exp_ff = '0;
    bit         mon_en = 0;
    bit         prev_valid = 0;

    always @(negedge clock) begin
        logic [4:0]    nxt;
        rsp_exp_t      e;
        fp_exe_in_type x;
        if (mon_en) begin
            if (reset) begin
                rq.delete();
                iq.delete();
                exp_ff     = '0;
                prev_valid = 0;
            end else begin
                check("fflags", 128'(fflags), 128'(exp_ff));
                if (fp_exe_i.enable) begin
                    if (iq.size() == 0) begin
                        check("spurious_enable", 128'(1), 128'(0));
                    end else begin
                        x = iq.pop_front();
                        check("exe_issue_fields", 128'(fp_exe_i), 128'(x));
                    end
                end else begin
                    check("exe_idle_zero", 128'(fp_exe_i), 128'(0));
                end
                nxt = fflags_clear ? 5'b0 : exp_ff;
                if (rsp_valid) begin
                    check("req_ready_in_resp", 128'(req_ready), 128'(0));
                    if (rq.size() == 0) begin
                        check("unexpected_rsp_valid", 128'(1), 128'(0));
                    end else begin
                        e = rq[0];
                        if (!prev_valid) check("rsp_latency", 128'(cyc), 128'(e.first_cyc));
                        check("rsp_result", 128'(rsp_result), 128'(e.result));
                        check("rsp_flags", 128'(rsp_flags), 128'(e.flags));
                        check("rsp_tag", 128'(rsp_tag), 128'(e.tag));
                        check("rsp_error", 128'(rsp_error), 128'(e.err));
                        if (flush) begin
                            check("flush_drop", 128'(1), 128'(e.drop));
                            void'(rq.pop_front());
                        end else if (rsp_ready) begin
                            nxt = nxt | e.flags;
                            void'(rq.pop_front());
                        end
                    end
                end
                prev_valid = rsp_valid && !rsp_ready && !flush;
                exp_ff = nxt;
            end
        end
    end

    bit clr_en = 0;
    always @(posedge clock) begin
        #1;
        if (clr_en) fflags_clear = ($urandom_range(0, 5) == 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit is_single(input fp_operation_type op);
        return op.fsgnj | op.fcmp | op.fmax | op.fclass | op.fmv | op.fcvt;
    endfunction

    task automatic run_op(input int kind, input fp_operation_type op,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                          input logic [31:0] res, input logic [4:0] flg,
                          input int lat, input int bp, input int fk, input bit clr_hs);
        int            a;
        int            last_k;
        rsp_exp_t      e;
        fp_exe_in_type x;
        logic [TW-1:0] tag;
        tag       = TW'($urandom);
        req_data1 = d1; req_data2 = d2; req_data3 = d3;
        req_op    = op;
        req_fmt   = 2'($urandom);
        req_rm    = 3'($urandom);
        req_tag   = tag;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        @(negedge clock);
        check("req_ready_idle", 128'(req_ready), 128'(1));
        a = cyc + 1;
        x = '0;
        x.enable = 1'b1; x.data1 = d1; x.data2 = d2; x.data3 = d3;
        x.op = op; x.fmt = req_fmt; x.rm = req_rm;
        iq.push_back(x);
        if (kind != K_FLUSH_WAIT) begin
            e.result    = (kind == K_TIMEOUT) ? 32'h0 : res;
            e.flags     = (kind == K_TIMEOUT) ? 5'h0 : flg;
            e.tag       = tag;
            e.err       = (kind == K_TIMEOUT);
            e.first_cyc = a + 1 + ((kind == K_TIMEOUT) ? TO : lat);
            e.drop      = (kind == K_FLUSH_RESP);
            rq.push_back(e);
        end
        tick();
        req_valid = 1'b0;
        last_k = (kind == K_TIMEOUT) ? TO : lat;
        for (int k = 0; k <= last_k; k++) begin
            fp_exe_o.ready  = (kind != K_TIMEOUT) && (k == lat);
            fp_exe_o.result = fp_exe_o.ready ? res : 32'h0;
            fp_exe_o.flags  = fp_exe_o.ready ? flg : 5'h0;
            flush = (kind == K_FLUSH_WAIT) && (k == fk);
            if (kind == K_FLUSH_WAIT && k == lat) begin
                @(negedge clock);
                check("busy_in_drain", 128'(busy), 128'(1));
            end
            tick();
        end
        fp_exe_o = '0;
        flush    = 1'b0;
        if (kind == K_FLUSH_WAIT) begin
            @(negedge clock);
            check("busy_after_drain", 128'(busy), 128'(0));
            tick();
            return;
        end
        for (int j = 0; j < bp; j++) begin
            flush = (kind == K_FLUSH_RESP) && (j == bp - 1);
            tick();
        end
        flush = 1'b0;
        if (kind != K_FLUSH_RESP) begin
            rsp_ready = 1'b1;
            if (clr_hs) fflags_clear = 1'b1;
            tick();
            rsp_ready = 1'b0;
            if (clr_hs) fflags_clear = 1'b0;
        end
    endtask

    initial begin
        fp_operation_type op;
        int kind, lat, bp, fk;
        fp_exe_in_type x;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("reset_req_ready", 128'(req_ready), 128'(1));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        check("reset_rsp_result", 128'(rsp_result), 128'(0));
        check("reset_rsp_flags", 128'(rsp_flags), 128'(0));
        check("reset_rsp_tag", 128'(rsp_tag), 128'(0));
        check("reset_rsp_error", 128'(rsp_error), 128'(0));
        check("reset_fflags", 128'(fflags), 128'(0));
        check("reset_exe_i", 128'(fp_exe_i), 128'(0));
        mon_en = 1;
        tick();

        op = '0; op.fsgnj = 1'b1;
        run_op(K_NORMAL, op, 32'h3F800000, 32'hBF800000, 32'h0, 32'hBF800000, 5'b00000, 0, 0, 0, 0);
        @(negedge clock);
        check("fflags_after_fsgnj", 128'(fflags), 128'(5'b00000));
        tick();

        op = '0; op.fdiv = 1'b1;
        run_op(K_NORMAL, op, 32'h3F800000, 32'h00000000, 32'h0, 32'h7F800000, 5'b01000, 6, 0, 0, 0);
        @(negedge clock);
        check("fflags_after_fdiv", 128'(fflags), 128'(5'b01000));
        tick();

        op = '0; op.fsqrt = 1'b1;
        run_op(K_TIMEOUT, op, 32'h40800000, 32'h0, 32'h0, 32'h0, 5'b0, 0, 0, 0, 0);
        op = '0; op.fmul = 1'b1;
        run_op(K_NORMAL, op, 32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 5'b00001, TO, 0, 0, 0);
        op = '0; op.fadd = 1'b1;
        run_op(K_FLUSH_WAIT, op, 32'h1, 32'h2, 32'h3, 32'hDEADBEEF, 5'b11111, 5, 0, 2, 0);
        op = '0; op.fmadd = 1'b1;
        run_op(K_NORMAL, op, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'b00100, 3, 5, 0, 0);
        @(negedge clock);
        check("fflags_after_backpressure", 128'(fflags), 128'(5'b01101));
        tick();

        clr_en = 1;
        for (int n = 0; n < 40; n++) begin
            op = fp_operation_type'(15'(1) << $urandom_range(0, 14));
            if (is_single(op)) begin
                kind = ($urandom_range(0, 3) == 0) ? K_FLUSH_RESP : K_NORMAL;
                lat  = 0;
            end else begin
                kind = $urandom_range(0, 3);
                lat  = $urandom_range(1, TO);
            end
            fk = 0;
            if (kind == K_FLUSH_WAIT) begin
                fk  = $urandom_range(1, TO - 4);
                lat = fk + 3;
            end
            bp = (kind == K_FLUSH_RESP) ? $urandom_range(1, 4) : $urandom_range(0, 3);
            run_op(kind, op, $urandom, $urandom, $urandom, $urandom, 5'($urandom), lat, bp, fk, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        clr_en = 0;
        fflags_clear = 1'b0;
        tick();

        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        @(negedge clock);
        check("fflags_cleared", 128'(fflags), 128'(5'b00000));
        tick();
        op = '0; op.fcmp = 1'b1;
        run_op(K_NORMAL, op, 32'h7FC00000, 32'h0, 32'h0, 32'h0, 5'b10000, 0, 0, 0, 0);
        @(negedge clock);
        check("fflags_prior_nv", 128'(fflags), 128'(5'b10000));
        tick();
        op = '0; op.fcvt = 1'b1;
        run_op(K_NORMAL, op, 32'h3FC00000, 32'h0, 32'h0, 32'h1, 5'b00001, 0, 0, 0, 1);
        @(negedge clock);
        check("fflags_clear_with_handshake", 128'(fflags), 128'(5'b00001));
        tick();

        op = '0; op.fdiv = 1'b1;
        req_data1 = 32'h1; req_data2 = 32'h2; req_data3 = 32'h3;
        req_op = op; req_fmt = 2'b0; req_rm = 3'b0; req_tag = 5'd7;
        x = '0; x.enable = 1'b1; x.data1 = 32'h1; x.data2 = 32'h2; x.data3 = 32'h3; x.op = op;
        iq.push_back(x);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("midop_reset_busy", 128'(busy), 128'(0));
        check("midop_reset_rsp_valid", 128'(rsp_valid), 128'(0));
        check("midop_reset_fflags", 128'(fflags), 128'(0));
        tick();

        op = '0; op.fmax = 1'b1;
        run_op(K_NORMAL, op, 32'h1, 32'h2, 32'h0, 32'h2, 5'b00000, 0, 0, 0, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
